// File: rtl/v_mul_issue.sv
// rtl/v_mul_issue.sv - request/response issue front end for the v_mult vector multiplier
module v_mul_issue #(
    parameter int LAT   = 2,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_opcode,
    input  logic [1:0]       req_precision,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      mul_a_o,
    output logic [31:0]      mul_b_o,
    output logic [1:0]       mul_opcode_o,
    output logic [1:0]       mul_precision_o,
    input  logic [31:0]      mul_out_i,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic             resp_err,
    output logic [TAG_W-1:0] resp_tag
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [OCC_W-1:0] occ;
    logic             accept;
    logic             pop;
    logic             push;

    assign req_ready = (occ < OCC_W'(DEPTH));
    assign accept    = req_valid && req_ready;
    assign pop       = resp_valid && resp_ready;

    // Credits cover pipe plus FIFO, so the non-stalling tracker always finds room.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ <= '0;
        end else if (accept && !pop) begin
            occ <= occ + 1'b1;
        end else if (!accept && pop) begin
            occ <= occ - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_a_o         <= '0;
            mul_b_o         <= '0;
            mul_opcode_o    <= '0;
            mul_precision_o <= '0;
        end else if (accept) begin
            mul_a_o         <= req_a;
            mul_b_o         <= req_b;
            mul_opcode_o    <= req_opcode;
            mul_precision_o <= (req_precision == 2'b11) ? 2'b10 : req_precision;
        end
    end

    logic [LAT-1:0]   trk_v;
    logic [LAT-1:0]   trk_e;
    logic [TAG_W-1:0] trk_t [LAT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trk_v <= '0;
            trk_e <= '0;
            for (int i = 0; i < LAT; i++) begin
                trk_t[i] <= '0;
            end
        end else begin
            trk_v[0] <= accept;
            trk_e[0] <= (req_precision == 2'b11);
            trk_t[0] <= req_tag;
            for (int i = 1; i < LAT; i++) begin
                trk_v[i] <= trk_v[i-1];
                trk_e[i] <= trk_e[i-1];
                trk_t[i] <= trk_t[i-1];
            end
        end
    end

    assign push = trk_v[LAT-1];

    logic [31:0]      fifo_d [DEPTH];
    logic             fifo_e [DEPTH];
    logic [TAG_W-1:0] fifo_t [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [OCC_W-1:0] cnt;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_d[wptr] <= trk_e[LAT-1] ? 32'd0 : mul_out_i;
            fifo_e[wptr] <= trk_e[LAT-1];
            fifo_t[wptr] <= trk_t[LAT-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                wptr <= ptr_next(wptr);
            end
            if (pop) begin
                rptr <= ptr_next(rptr);
            end
            if (push && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (!push && pop) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Head is masked while empty so the uninitialised storage never reaches the port.
    assign resp_valid = (cnt != '0);
    assign resp_data  = resp_valid ? fifo_d[rptr] : 32'd0;
    assign resp_err   = resp_valid ? fifo_e[rptr] : 1'b0;
    assign resp_tag   = resp_valid ? fifo_t[rptr] : '0;

endmodule

// File: tb/tb_v_mul_issue.sv
// tb/tb_v_mul_issue.sv - directed self-checking bench for v_mul_issue
module tb_v_mul_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_opcode;
    logic [1:0]  req_precision;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_tag;
    logic [31:0] mul_a_o;
    logic [31:0] mul_b_o;
    logic [1:0]  mul_opcode_o;
    logic [1:0]  mul_precision_o;
    logic [31:0] mul_out_i;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [3:0]  resp_tag;

    int total = 0;
    int bad   = 0;
    int acc;

    v_mul_issue #(.LAT(2), .DEPTH(4), .TAG_W(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_opcode      (req_opcode),
        .req_precision   (req_precision),
        .req_a           (req_a),
        .req_b           (req_b),
        .req_tag         (req_tag),
        .mul_a_o         (mul_a_o),
        .mul_b_o         (mul_b_o),
        .mul_opcode_o    (mul_opcode_o),
        .mul_precision_o (mul_precision_o),
        .mul_out_i       (mul_out_i),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_data       (resp_data),
        .resp_err        (resp_err),
        .resp_tag        (resp_tag)
    );

    always #5 clk = ~clk;

    // Stand-in for v_mult: one register stage after the launch registers gives LAT=2.
    function automatic logic [31:0] vmul(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] op, input logic [1:0] prec);
        int          w;
        logic [63:0] mask;
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        logic [63:0] res;
        w    = (prec == 2'b00) ? 8 : (prec == 2'b01) ? 16 : 32;
        mask = (64'd1 << w) - 64'd1;
        res  = '0;
        for (int i = 0; i < 32 / w; i++) begin
            ea = (64'(a) >> (i * w)) & mask;
            eb = (64'(b) >> (i * w)) & mask;
            if ((op == 2'b01 || op == 2'b11) && ea[w-1]) ea = ea | ~mask;
            if (op == 2'b01 && eb[w-1]) eb = eb | ~mask;
            p   = ea * eb;
            res = res | ((((op == 2'b00) ? p : (p >> w)) & mask) << (i * w));
        end
        return res[31:0];
    endfunction

    always @(posedge clk) mul_out_i <= vmul(mul_a_o, mul_b_o, mul_opcode_o, mul_precision_o);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [1:0] prec,
                        input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        int n = 0;
        req_opcode    = op;
        req_precision = prec;
        req_a         = a;
        req_b         = b;
        req_tag       = tag;
        req_valid     = 1'b1;
        while (!req_ready && n < 50) begin
            step();
            n++;
        end
        chk("send_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic expect_resp(input string name, input logic [31:0] d, input logic e,
                               input logic [3:0] t, input int budget);
        int n = 0;
        while (!resp_valid && n < budget) begin
            step();
            n++;
        end
        chk({name, "_valid"}, 32'(resp_valid), 32'd1);
        chk({name, "_data"}, resp_data, d);
        chk({name, "_err"}, 32'(resp_err), 32'(e));
        chk({name, "_tag"}, 32'(resp_tag), 32'(t));
        step();
    endtask

    initial begin
        rst           = 1'b0;
        req_valid     = 1'b0;
        req_opcode    = '0;
        req_precision = '0;
        req_a         = '0;
        req_b         = '0;
        req_tag       = '0;
        resp_ready    = 1'b0;
        step();
        step();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_tag", 32'(resp_tag), 32'd0);
        chk("rst_mul_a", mul_a_o, 32'd0);
        chk("rst_mul_prec", 32'(mul_precision_o), 32'd0);
        rst = 1'b1;
        step();

        // Basic 8-bit mul, latency check
        resp_ready = 1'b1;
        send(2'b00, 2'b00, 32'h01010101, 32'h01010101, 4'd3);
        chk("lat_t0", 32'(resp_valid), 32'd0);
        step();
        chk("lat_t1", 32'(resp_valid), 32'd0);
        step();
        expect_resp("basic", 32'h01010101, 1'b0, 4'd3, 0);
        step();

        // Back-to-back opcodes with results on consecutive cycles
        fork
            begin
                send(2'b01, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd1);
                send(2'b10, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd2);
                send(2'b10, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd3);
                send(2'b00, 2'b10, 32'hF0F0F0F0, 32'h00000001, 4'd4);
            end
            begin
                expect_resp("b2b_mulh", 32'h00000000, 1'b0, 4'd1, 10);
                expect_resp("b2b_mulhu8", 32'hFEFEFEFE, 1'b0, 4'd2, 0);
                expect_resp("b2b_mulhu32", 32'hFFFFFFFE, 1'b0, 4'd3, 0);
                expect_resp("b2b_mul32", 32'hF0F0F0F0, 1'b0, 4'd4, 0);
            end
        join
        step();

        // Full backpressure
        resp_ready = 1'b0;
        acc        = 0;
        req_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            req_opcode    = 2'b00;
            req_precision = 2'b10;
            req_a         = 32'(i + 1);
            req_b         = 32'd3;
            req_tag       = 4'(i);
            if (req_ready) acc++;
            step();
        end
        req_valid = 1'b0;
        chk("bp_accepts", 32'(acc), 32'd4);
        chk("bp_ready_low", 32'(req_ready), 32'd0);
        resp_ready = 1'b1;
        expect_resp("bp0", 32'd3, 1'b0, 4'd0, 0);
        chk("bp_ready_rise", 32'(req_ready), 32'd1);
        expect_resp("bp1", 32'd6, 1'b0, 4'd1, 0);
        expect_resp("bp2", 32'd9, 1'b0, 4'd2, 0);
        expect_resp("bp3", 32'd12, 1'b0, 4'd3, 0);
        chk("bp_drained", 32'(resp_valid), 32'd0);
        step();

        // Illegal precision between two legal requests, head held under backpressure
        resp_ready = 1'b0;
        send(2'b00, 2'b00, 32'h02030405, 32'h02030405, 4'd5);
        send(2'b00, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd6);
        chk("ill_launch_prec", 32'(mul_precision_o), 32'd2);
        send(2'b00, 2'b00, 32'h10101010, 32'h02020202, 4'd7);
        step();
        step();
        step();
        chk("ill_occ_ready", 32'(req_ready), 32'd1);
        chk("ill_hold0", resp_data, 32'h04091019);
        step();
        chk("ill_hold1", resp_data, 32'h04091019);
        resp_ready = 1'b1;
        expect_resp("ill_pre", 32'h04091019, 1'b0, 4'd5, 0);
        expect_resp("ill_mid", 32'h00000000, 1'b1, 4'd6, 0);
        expect_resp("ill_post", 32'h20202020, 1'b0, 4'd7, 0);
        step();

        // Fill to DEPTH, then accept and pop in the same cycles
        resp_ready = 1'b0;
        send(2'b00, 2'b10, 32'd10, 32'd5, 4'd8);
        send(2'b00, 2'b10, 32'd11, 32'd5, 4'd9);
        send(2'b00, 2'b10, 32'd12, 32'd5, 4'd10);
        send(2'b00, 2'b10, 32'd13, 32'd5, 4'd11);
        repeat (4) step();
        chk("full_ready_low", 32'(req_ready), 32'd0);
        fork
            begin
                resp_ready = 1'b1;
                expect_resp("full0", 32'd50, 1'b0, 4'd8, 0);
                expect_resp("full1", 32'd55, 1'b0, 4'd9, 0);
                expect_resp("full2", 32'd60, 1'b0, 4'd10, 0);
                expect_resp("full3", 32'd65, 1'b0, 4'd11, 0);
                expect_resp("full4", 32'd140, 1'b0, 4'd12, 0);
                expect_resp("full5", 32'd147, 1'b0, 4'd13, 0);
                expect_resp("full6", 32'd154, 1'b0, 4'd14, 0);
            end
            begin
                send(2'b00, 2'b10, 32'd20, 32'd7, 4'd12);
                chk("pp_occ0", 32'(req_ready), 32'd1);
                send(2'b00, 2'b10, 32'd21, 32'd7, 4'd13);
                chk("pp_occ1", 32'(req_ready), 32'd1);
                send(2'b00, 2'b10, 32'd22, 32'd7, 4'd14);
                chk("pp_occ2", 32'(req_ready), 32'd1);
            end
        join
        chk("full_drained", 32'(resp_valid), 32'd0);
        step();

        // Reset mid-flight
        send(2'b00, 2'b00, 32'h01010101, 32'h02020202, 4'd1);
        send(2'b00, 2'b00, 32'h01010101, 32'h03030303, 4'd2);
        send(2'b00, 2'b00, 32'h01010101, 32'h04040404, 4'd3);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_mul_a", mul_a_o, 32'd0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("post_rst_valid", 32'(resp_valid), 32'd0);
            chk("post_rst_ready", 32'(req_ready), 32'd1);
            step();
        end
        send(2'b00, 2'b00, 32'h03030303, 32'h05050505, 4'd9);
        expect_resp("post_rst", 32'h0F0F0F0F, 1'b0, 4'd9, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
